// File: rtl/hb_system_timer_pkg.sv
// rtl/hb_system_timer_pkg.sv - HB slave bus types and machine timer register addresses
package hb_system_timer_pkg;

  typedef struct packed {
    logic [7:0]  raddr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } hb_slave_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

  localparam logic [7:0] HB_MTIME_LO    = 8'd12;
  localparam logic [7:0] HB_MTIME_HI    = 8'd16;
  localparam logic [7:0] HB_MTIMECMP_LO = 8'd20;
  localparam logic [7:0] HB_MTIMECMP_HI = 8'd24;

endpackage

// File: rtl/hb_tick_prescaler.sv
// rtl/hb_tick_prescaler.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module hb_tick_prescaler #(
  parameter int unsigned TICK_DIV = 12
) (
  input  logic hb_clk,
  input  logic rst_n,
  output logic tick
);

  logic [15:0] r_count;
  logic        w_last;

  assign w_last = (r_count == 16'(TICK_DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

// File: rtl/hb_system_timer.sv
// rtl/hb_system_timer.sv - RISC-V machine timer (mtime/mtimecmp) HB slave with timer interrupt
module hb_system_timer
  import hb_system_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12
) (
  input  logic        hb_clk,
  input  logic        rst_n,
  input  hb_slave_t   xt_hb,
  input  sel_t        sel,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow_hi;
  logic [31:0] r_rdata;
  logic        r_irq;
  logic        w_tick;
  logic [31:0] w_rd_val;

  hb_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .hb_clk (hb_clk),
    .rst_n  (rst_n),
    .tick   (w_tick)
  );

  // MTIME_HI returns the half captured by the last MTIME_LO read, keeping LO/HI pairs coherent
  always_comb begin
    w_rd_val = '0;
    case (xt_hb.raddr)
      HB_MTIME_LO:    w_rd_val = r_mtime[31:0];
      HB_MTIME_HI:    w_rd_val = r_shadow_hi;
      HB_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
      HB_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
      default:        w_rd_val = '0;
    endcase
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_shadow_hi <= '0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      // A software write to either mtime half suppresses that cycle's increment
      if (sel.wen && xt_hb.waddr == HB_MTIME_LO) begin
        r_mtime[31:0] <= xt_hb.wdata;
      end else if (sel.wen && xt_hb.waddr == HB_MTIME_HI) begin
        r_mtime[63:32] <= xt_hb.wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (sel.wen && xt_hb.waddr == HB_MTIMECMP_LO) r_mtimecmp[31:0]  <= xt_hb.wdata;
      if (sel.wen && xt_hb.waddr == HB_MTIMECMP_HI) r_mtimecmp[63:32] <= xt_hb.wdata;

      if (sel.ren) begin
        r_rdata <= w_rd_val;
        if (xt_hb.raddr == HB_MTIME_LO) r_shadow_hi <= r_mtime[63:32];
      end

      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign rdata     = r_rdata;
  assign timer_irq = r_irq;

endmodule

// File: tb/tb_hb_system_timer.sv
// tb/tb_hb_system_timer.sv - self-checking bench for hb_system_timer with a behavioural timer model
module tb_hb_system_timer;
  import hb_system_timer_pkg::*;

  localparam int unsigned DIV = 12;

  logic        hb_clk = 1'b0;
  logic        rst_n;
  hb_slave_t   xt_hb;
  sel_t        sel;
  logic [31:0] rdata;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: 64-bit counters and a cycle count since reset release
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  logic [31:0] m_rdata;
  logic        m_irq;
  int unsigned m_cyc;

  hb_system_timer #(.TICK_DIV(DIV)) dut (
    .hb_clk    (hb_clk),
    .rst_n     (rst_n),
    .xt_hb     (xt_hb),
    .sel       (sel),
    .rdata     (rdata),
    .timer_irq (timer_irq)
  );

  always #5 hb_clk = ~hb_clk;

  function automatic logic m_tick_next();
    return (m_cyc % DIV) == DIV - 1;
  endfunction

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = {64{1'b1}};
    m_shadow = 32'd0;
    m_rdata  = 32'd0;
    m_irq    = 1'b0;
    m_cyc    = 0;
  endtask

  task automatic model_step();
    logic        tick;
    logic [31:0] rv;
    tick = m_tick_next();
    m_cyc++;
    rv = 32'd0;
    if (xt_hb.raddr == 8'd12) rv = m_mtime[31:0];
    if (xt_hb.raddr == 8'd16) rv = m_shadow;
    if (xt_hb.raddr == 8'd20) rv = m_cmp[31:0];
    if (xt_hb.raddr == 8'd24) rv = m_cmp[63:32];
    if (sel.ren) begin
      m_rdata = rv;
      if (xt_hb.raddr == 8'd12) m_shadow = m_mtime[63:32];
    end
    m_irq = (m_mtime >= m_cmp);
    if (sel.wen && xt_hb.waddr == 8'd12)      m_mtime = {m_mtime[63:32], xt_hb.wdata};
    else if (sel.wen && xt_hb.waddr == 8'd16) m_mtime = {xt_hb.wdata, m_mtime[31:0]};
    else if (tick)                            m_mtime = m_mtime + 64'd1;
    if (sel.wen && xt_hb.waddr == 8'd20) m_cmp = {m_cmp[63:32], xt_hb.wdata};
    if (sel.wen && xt_hb.waddr == 8'd24) m_cmp = {xt_hb.wdata, m_cmp[31:0]};
  endtask

  task automatic step();
    model_step();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    sel = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_op(input logic ren, input logic [7:0] ra, input logic wen,
                        input logic [7:0] wa, input logic [31:0] wd);
    xt_hb.raddr = ra;
    xt_hb.waddr = wa;
    xt_hb.wdata = wd;
    sel.ren     = ren;
    sel.wen     = wen;
    step();
    sel = '0;
  endtask

  task automatic rd(input logic [7:0] a);
    bus_op(1'b1, a, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_op(1'b0, 8'd0, 1'b1, a, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    xt_hb = '0;
    sel   = '0;
    model_reset();
    #12;
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'd0); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
    rst_n = 1'b1;
    idle(3 * DIV);
    rd(8'd12);
    n_checks++; if (rdata !== 32'd3) begin n_fail++; $display("FAIL idle_mtime_lo: got %h expected %h", rdata, 32'd3); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL idle_irq: got %b expected 0", timer_irq); end
    rd(8'd24);
    n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp_hi: got %h expected %h", rdata, 32'hFFFF_FFFF); end
  endtask

  task automatic test_carry();
    wr(8'd12, 32'hFFFF_FFFF);
    wr(8'd16, 32'd0);
    idle(DIV);
    rd(8'd12);
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL carry_lo: got %h expected %h", rdata, 32'd0); end
    rd(8'd16);
    n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL carry_hi: got %h expected %h", rdata, 32'd1); end
  endtask

  task automatic test_shadow();
    wr(8'd12, 32'hFFFF_FFFF);
    wr(8'd16, 32'd5);
    rd(8'd12);
    n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL shadow_lo: got %h expected %h", rdata, 32'hFFFF_FFFF); end
    idle(DIV);
    rd(8'd16);
    n_checks++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL shadow_hi_old: got %h expected %h", rdata, 32'd5); end
    rd(8'd12);
    rd(8'd16);
    n_checks++; if (rdata !== 32'd6) begin n_fail++; $display("FAIL shadow_hi_new: got %h expected %h", rdata, 32'd6); end
  endtask

  task automatic test_irq();
    int i;
    wr(8'd16, 32'd0);
    wr(8'd12, 32'd0);
    wr(8'd24, 32'd0);
    wr(8'd20, 32'd10);
    for (i = 0; i < 20 * DIV && m_mtime != 64'd10; i++) idle(1);
    n_checks++; if (m_mtime != 64'd10) begin n_fail++; $display("FAIL irq_wait: timeout, mtime %0d expected 10", m_mtime); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle: got %b expected 0", timer_irq); end
    idle(1);
    n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", timer_irq); end
    wr(8'd20, 32'hFFFF_FFFF);
    n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b expected 1", timer_irq); end
    idle(1);
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", timer_irq); end
  endtask

  task automatic test_tick_write();
    int i;
    for (i = 0; i < DIV && !m_tick_next(); i++) idle(1);
    n_checks++; if (!m_tick_next()) begin n_fail++; $display("FAIL tick_align: timeout, tick not found"); end
    wr(8'd12, 32'd7);
    rd(8'd12);
    n_checks++; if (rdata !== 32'd7) begin n_fail++; $display("FAIL tick_write_lo: got %h expected %h", rdata, 32'd7); end
    idle(DIV - 1);
    rd(8'd12);
    n_checks++; if (rdata !== 32'd8) begin n_fail++; $display("FAIL tick_after_write: got %h expected %h", rdata, 32'd8); end
    rd(8'd13);
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", rdata, 32'd0); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [7];
    addrs = '{8'd12, 8'd16, 8'd20, 8'd24, 8'd13, 8'd0, 8'd28};
    for (int i = 0; i < 400; i++) begin
      xt_hb.raddr = addrs[$urandom_range(0, 6)];
      xt_hb.waddr = ($urandom_range(0, 3) == 0) ? xt_hb.raddr : addrs[$urandom_range(0, 6)];
      xt_hb.wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      sel.ren     = ($urandom_range(0, 2) == 0);
      sel.wen     = ($urandom_range(0, 4) == 0);
      step();
      n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rdata, m_rdata); end
      n_checks++; if (timer_irq !== m_irq) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, timer_irq, m_irq); end
    end
    sel = '0;
  endtask

  task automatic test_reset_mid();
    wr(8'd20, 32'd0);
    wr(8'd24, 32'd0);
    wr(8'd12, 32'h1234);
    rd(8'd12);
    idle(2);
    n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", timer_irq); end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: got %b expected 0", timer_irq); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL async_reset_rdata: got %h expected %h", rdata, 32'd0); end
    @(posedge hb_clk);
    #1;
    rst_n = 1'b1;
    rd(8'd12);
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL post_reset_lo: got %h expected %h", rdata, 32'd0); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq: got %b expected 0", timer_irq); end
    idle(DIV - 1);
    rd(8'd12);
    n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL first_tick: got %h expected %h", rdata, 32'd1); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_shadow();
    test_irq();
    test_tick_write();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
